// File: rtl/multicycle_control_unit_if.sv
// Instruction- and data-memory request/ready bundle for multicycle_control_unit.
interface multicycle_control_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              imem_req;
  logic              imem_ready;
  logic [8:0]        imem_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_req, input imem_ready, imem_data,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );
  modport slave (
    input  imem_req, output imem_ready, imem_data,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit-instruction CPU with stallable memories.
// Optional PERF_CNT_EN adds saturating active-cycle and retired-instruction counters.
module multicycle_control_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREG   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  multicycle_control_unit_if.master mem,
  output logic [$clog2(NREG)-1:0]  rf_raddr_a,
  output logic [$clog2(NREG)-1:0]  rf_raddr_b,
  input  logic [DATA_W-1:0]        rf_rdata_a,
  input  logic [DATA_W-1:0]        rf_rdata_b,
  output logic                     rf_we,
  output logic [$clog2(NREG)-1:0]  rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [3:0]               alu_op,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic                     alu_zero,
  output logic [2:0]               lut_type,
  input  logic [ADDR_W-1:0]        lut_out,
  output logic [4:0]               immediate,
  output logic                     pc_inc,
  output logic                     pc_branch,
  output logic                     halted
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]              perf_cycles,
  output logic [31:0]              perf_retired
`endif
);
  localparam int RW = $clog2(NREG);

  localparam logic [2:0] OP_LW  = 3'd0, OP_SW  = 3'd1, OP_SET = 3'd2, OP_ADD = 3'd3,
                         OP_SLL = 3'd4, OP_NEG = 3'd5, OP_BR  = 3'd6, OP_MOV = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [8:0]        ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

  logic [2:0] opc;
  logic [1:0] fn;
  logic       is_lwr, is_halt, is_undef, is_load, is_mem, is_br, br_taken;
  logic       unused_rdata_b;

  assign opc      = ir_q[8:6];
  assign fn       = ir_q[1:0];
  assign is_lwr   = (opc == OP_ADD) && (fn == 2'd3);
  assign is_halt  = (opc == OP_NEG) && (fn == 2'd3);
  assign is_undef = (opc == OP_SLL) && (fn == 2'd3);
  assign is_load  = (opc == OP_LW) || is_lwr;
  assign is_mem   = is_load || (opc == OP_SW);
  assign is_br    = (opc == OP_BR);
  // operand B only feeds the external ALU
  assign unused_rdata_b = ^rf_rdata_b;

  always_comb begin
    case (fn)
      2'd0:    br_taken = alu_zero;
      2'd1:    br_taken = !alu_zero;
      default: br_taken = alu_out[0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    a_d          = a_q;
    res_d        = res_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_we_d    = dmem_we_q;
    dmem_wdata_d = dmem_wdata_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (mem.imem_ready) begin
        ir_d    = mem.imem_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rf_rdata_a;
        state_d = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        res_d = alu_out;
        if (is_br) state_d = S_FETCH;
        else if (is_mem) begin
          // address/data captured here so they stay stable through any stall
          dmem_addr_d  = is_lwr ? ADDR_W'(a_q) : lut_out;
          dmem_we_d    = (opc == OP_SW);
          dmem_wdata_d = (opc == OP_SW) ? a_q : '0;
          state_d      = S_MEM;
        end else state_d = S_WB;
      end
      S_MEM: if (mem.dmem_ready) begin
        if (is_load) res_d = mem.dmem_rdata;
        dmem_addr_d  = '0;
        dmem_we_d    = 1'b0;
        dmem_wdata_d = '0;
        state_d      = is_load ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ir_q         <= '0;
      a_q          <= '0;
      res_q        <= '0;
      dmem_addr_q  <= '0;
      dmem_we_q    <= 1'b0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      res_q        <= res_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_we_q    <= dmem_we_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign mem.imem_req   = (state_q == S_FETCH);
  assign mem.dmem_req   = (state_q == S_MEM);
  assign mem.dmem_we    = dmem_we_q;
  assign mem.dmem_addr  = dmem_addr_q;
  assign mem.dmem_wdata = dmem_wdata_q;
  assign halted         = (state_q == S_HALT);

  // register indices stay up through EXEC so the ALU sees its operands
  always_comb begin
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    if (state_q == S_DECODE || state_q == S_EXEC) begin
      case (opc)
        OP_ADD, OP_SLL, OP_NEG, OP_BR: rf_raddr_b = RW'(1);
        OP_MOV:  rf_raddr_a = RW'(ir_q[5:2]);
        OP_SW:   rf_raddr_a = RW'(ir_q[5]);
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_op   = 4'd0;
    lut_type = 3'd0;
    if (state_q == S_EXEC) begin
      case (opc)
        OP_ADD:  alu_op = (fn == 2'd3) ? 4'd0 : {2'b00, fn};
        OP_SLL:  alu_op = (fn == 2'd3) ? 4'd2 : 4'd3 + {2'b00, fn};
        OP_NEG:  alu_op = 4'd6 + {2'b00, fn};
        OP_BR:   alu_op = fn[1] ? 4'd9 + {3'b000, fn[0]} : 4'd2;
        default: alu_op = 4'd0;
      endcase
      case (opc)
        OP_LW:   lut_type = 3'd0;
        OP_SW:   lut_type = 3'd1;
        OP_BR:   lut_type = 3'd2 + {1'b0, fn};
        default: lut_type = 3'd0;
      endcase
    end
  end

  always_comb begin
    immediate = 5'd0;
    if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (opc)
        OP_LW, OP_SW, OP_SET: immediate = ir_q[4:0];
        OP_BR:   immediate = {1'b0, ir_q[5:2]};
        default: immediate = 5'd0;
      endcase
    end
  end

  always_comb begin
    rf_we    = (state_q == S_WB) && !is_undef;
    rf_waddr = '0;
    rf_wdata = '0;
    if (rf_we) begin
      case (opc)
        OP_LW, OP_SET:         rf_waddr = RW'(ir_q[5]);
        OP_MOV:                rf_waddr = RW'(ir_q[1]);
        OP_ADD, OP_SLL, OP_NEG: rf_waddr = RW'(ir_q[5:2]);
        default:               rf_waddr = '0;
      endcase
      case (opc)
        OP_SET:  rf_wdata = DATA_W'(ir_q[4:0]);
        OP_MOV:  rf_wdata = a_q;
        default: rf_wdata = res_q;
      endcase
    end
  end

  assign pc_branch = (state_q == S_EXEC) && is_br && br_taken;
  assign pc_inc    = (state_q == S_WB)
                   || ((state_q == S_EXEC) && is_br && !br_taken)
                   || ((state_q == S_MEM) && mem.dmem_ready && (opc == OP_SW));

`ifdef PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_retired_q, perf_retired_d;

  always_comb begin
    perf_cycles_d  = perf_cycles_q;
    perf_retired_d = perf_retired_q;
    if (state_q != S_IDLE && state_q != S_HALT && perf_cycles_q != '1)
      perf_cycles_d = perf_cycles_q + 32'd1;
    if ((pc_inc || pc_branch) && perf_retired_q != '1)
      perf_retired_d = perf_retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q  <= '0;
      perf_retired_q <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_retired_q <= perf_retired_d;
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_retired = perf_retired_q;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: small RF/ALU models, hand-computed expectations.
module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [7:0] rf_rdata_a, rf_rdata_b, rf_wdata, alu_out, lut_out;
  logic       rf_we, alu_zero, pc_inc, pc_branch, halted;
  logic [3:0] alu_op;
  logic [2:0] lut_type;
  logic [4:0] immediate;
  logic [7:0] regs [16];
  int total = 0;
  int bad   = 0;

  multicycle_control_unit_if #(.DATA_W(8), .ADDR_W(8)) mif ();

  multicycle_control_unit #(.DATA_W(8), .ADDR_W(8), .NREG(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mem(mif),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_out(alu_out), .alu_zero(alu_zero),
    .lut_type(lut_type), .lut_out(lut_out), .immediate(immediate),
    .pc_inc(pc_inc), .pc_branch(pc_branch), .halted(halted)
  );

  always #5 clk = ~clk;

  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = regs[rf_raddr_b];
  assign alu_zero   = (alu_out == 8'd0);
  always_comb begin
    case (alu_op)
      4'd0:    alu_out = rf_rdata_a + rf_rdata_b;
      4'd2:    alu_out = rf_rdata_a - rf_rdata_b;
      4'd7:    alu_out = rf_rdata_a & rf_rdata_b;
      4'd8:    alu_out = rf_rdata_a | rf_rdata_b;
      4'd10:   alu_out = {7'd0, rf_rdata_a < rf_rdata_b};
      default: alu_out = 8'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [8:0] ins);
    mif.imem_data  = ins;
    mif.imem_ready = 1'b1;
    tick();
    mif.imem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; lut_out = 8'h20;
    mif.imem_ready = 1'b0; mif.imem_data = '0;
    mif.dmem_ready = 1'b0; mif.dmem_rdata = '0;
    for (int i = 0; i < 16; i++) regs[i] = 8'(i);
    regs[0] = 8'd3; regs[1] = 8'd3;
    tick(); tick();
    reset = 1'b0;
    chk("rst_halted", halted, 0);
    chk("rst_imem_req", mif.imem_req, 0);
    chk("rst_dmem_req", mif.dmem_req, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pc_inc", pc_inc, 0);
    tick();
    chk("idle_imem_req", mif.imem_req, 0);

    // SET r1,5 : WB four cycles after start
    start = 1'b1; tick(); start = 1'b0;
    chk("set_fetch_req", mif.imem_req, 1);
    fetch(9'b010_1_00101);
    chk("set_dec_req", mif.imem_req, 0);
    tick();
    chk("set_exec_rf_we", rf_we, 0);
    tick();
    chk("set_wb_we", rf_we, 1);
    chk("set_wb_waddr", rf_waddr, 1);
    chk("set_wb_wdata", rf_wdata, 5);
    chk("set_wb_imm", immediate, 5);
    chk("set_wb_pc_inc", pc_inc, 1);
    chk("set_wb_pc_br", pc_branch, 0);
    tick();
    chk("set_next_fetch", mif.imem_req, 1);
    chk("set_next_we", rf_we, 0);

    // BEQ with r0==r1 : taken in EXEC
    fetch(9'b110_0000_00);
    chk("beq_raddr_b", rf_raddr_b, 1);
    tick();
    chk("beq_alu_op", alu_op, 2);
    chk("beq_lut_type", lut_type, 2);
    chk("beq_pc_branch", pc_branch, 1);
    chk("beq_pc_inc", pc_inc, 0);
    chk("beq_rf_we", rf_we, 0);
    tick();
    chk("beq_next_fetch", mif.imem_req, 1);
    chk("beq_next_br", pc_branch, 0);

    // BNE with r0==r1 : not taken
    fetch(9'b110_0000_01);
    tick();
    chk("bne_lut_type", lut_type, 3);
    chk("bne_pc_inc", pc_inc, 1);
    chk("bne_pc_branch", pc_branch, 0);
    tick();

    // SW r1 with lut_out=0x20, dmem_ready in the 4th MEM cycle
    regs[1] = 8'hAB;
    fetch(9'b001_1_00100);
    chk("sw_raddr_a", rf_raddr_a, 1);
    tick();
    chk("sw_lut_type", lut_type, 1);
    chk("sw_imm", immediate, 4);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mif.dmem_ready = 1'b1;
      #1;
      chk("sw_req", mif.dmem_req, 1);
      chk("sw_addr", mif.dmem_addr, 8'h20);
      chk("sw_wdata", mif.dmem_wdata, 8'hAB);
      chk("sw_we", mif.dmem_we, 1);
      chk("sw_pc_inc", pc_inc, (i == 3) ? 1 : 0);
      tick();
    end
    mif.dmem_ready = 1'b0;
    chk("sw_done_req", mif.dmem_req, 0);
    chk("sw_done_fetch", mif.imem_req, 1);
    chk("sw_done_pc_inc", pc_inc, 0);

    // ADD r2 = r0 + r1 = 0x03 + 0xAB
    fetch(9'b011_0010_00);
    tick();
    chk("add_alu_op", alu_op, 0);
    tick();
    chk("add_wb_waddr", rf_waddr, 2);
    chk("add_wb_wdata", rf_wdata, 8'hAE);
    tick();

    // MOV r1 <- r4 (dest IR[1], source IR[5:2])
    fetch(9'b111_0100_10);
    chk("mov_raddr_a", rf_raddr_a, 4);
    tick(); tick();
    chk("mov_wb_waddr", rf_waddr, 1);
    chk("mov_wb_wdata", rf_wdata, 8'h04);
    tick();

    // undefined SLL-group funct: SUB, no writeback, still retires
    fetch(9'b100_0000_11);
    tick();
    chk("undef_alu_op", alu_op, 2);
    tick();
    chk("undef_rf_we", rf_we, 0);
    chk("undef_pc_inc", pc_inc, 1);
    tick();

    // LWR r5 <- mem[r0]
    regs[0] = 8'h10; mif.dmem_rdata = 8'h7E;
    fetch(9'b011_0101_11);
    chk("lwr_raddr_a", rf_raddr_a, 0);
    tick(); tick();
    mif.dmem_ready = 1'b1;
    #1;
    chk("lwr_req", mif.dmem_req, 1);
    chk("lwr_addr", mif.dmem_addr, 8'h10);
    chk("lwr_we", mif.dmem_we, 0);
    chk("lwr_mem_pc_inc", pc_inc, 0);
    tick();
    mif.dmem_ready = 1'b0;
    chk("lwr_wb_we", rf_we, 1);
    chk("lwr_wb_waddr", rf_waddr, 5);
    chk("lwr_wb_wdata", rf_wdata, 8'h7E);
    chk("lwr_wb_pc_inc", pc_inc, 1);
    tick();

    // HALT: sticky until reset, start ignored
    fetch(9'b101_0000_11);
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_imem_req", mif.imem_req, 0);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("halt_stay", halted, 1);
    chk("halt_no_fetch", mif.imem_req, 0);
    chk("halt_no_pc", pc_inc, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_req", mif.imem_req, 0);

    // reset mid-MEM of an LW, then a late dmem_ready
    start = 1'b1; tick(); start = 1'b0;
    fetch(9'b000_1_00011);
    tick(); tick();
    chk("lw_mem_req", mif.dmem_req, 1);
    chk("lw_mem_addr", mif.dmem_addr, 8'h20);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mrst_req", mif.dmem_req, 0);
    chk("mrst_addr", mif.dmem_addr, 0);
    mif.dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mrst_rf_we", rf_we, 0);
      chk("mrst_idle_req", mif.imem_req, 0);
      tick();
    end
    mif.dmem_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle decoder/controller of the 9-bit-instruction CPU.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Uses ready handshakes to instruction and data memory, so both memories may stall.
- Generalised datapath width. Drives the register file, ALU, address LUT and PC logic. Adds halt and start control.

Parameters:
DATA_W, 8, datapath/register/memory-data width (>=8)
ADDR_W, 8, data-memory address width
NREG, 16, register count (>=16); 4-bit instruction reg fields are zero-extended to $clog2(NREG)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  leave IDLE and begin fetching (sampled only in IDLE)
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
imem_data  in  9  instruction word
dmem_req  out  1  data memory request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  ADDR_W  data address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data, valid with dmem_ready
dmem_ready  in  1  data access complete
rf_raddr_a, rf_raddr_b  out  $clog2(NREG)  read indices
rf_rdata_a, rf_rdata_b  in  DATA_W  read values (combinational)
rf_we  out  1  register write strobe
rf_waddr  out  $clog2(NREG)  write index
rf_wdata  out  DATA_W  write value
alu_op  out  4  ADD0 ADDC1 SUB2 SLL3 SRA4 SRL5 NEG6 AND7 OR8 LTS9 LT10
alu_out  in  DATA_W  ALU result
alu_zero  in  1  ALU result zero
lut_type  out  3  LW0 SW1 BEQ2 BNE3 BLTS4 BLT5
lut_out  in  ADDR_W  LUT-resolved address
immediate  out  5  decoded immediate (I: instr[4:0]; B: {0,instr[5:2]}; else 0)
pc_inc  out  1  one-cycle pulse: advance PC sequentially
pc_branch  out  1  one-cycle pulse: load branch target
halted  out  1  core halted

Behaviour:
- Decode: opcode=IR[8:6], funct=IR[1:0].
- Opcodes: LW0, SW1, SET2, ADDgrp3 (ADD, ADDC, SUB, LWR), SLLgrp4 (SLL, SRA, SRL, -), NEGgrp5 (NEG, AND, OR, HALT), BRgrp6 (BEQ, BNE, BLTS, BLT), MOV7.
- Reset (any state): next state IDLE, IR=0, halted=0. All strobes/requests are 0 and all addresses/data are 0 from the cycle after the reset edge.
- IDLE: all outputs 0; start=1 -> FETCH.
- FETCH: imem_req=1, held until imem_ready=1; then IR<=imem_data -> DECODE.
- DECODE (1 cycle): register indices driven from IR; operands A, B latched.
  - R/BR groups read r0/r1.
  - MOV reads IR[5:2].
  - SW reads IR[5].
  - LWR reads r0.
  - HALT -> HALTED. Otherwise -> EXEC.
- EXEC (1 cycle): alu_op decoded from funct; result latched.
  - Undefined funct (SLLgrp funct3) executes as SUB with no writeback.
  - BR: pc_branch=1 if taken (BEQ: alu_zero; BNE: !alu_zero; BLTS/BLT: alu_out[0]), else pc_inc=1. Then -> FETCH.
  - LW/SW/LWR -> MEM. All others -> WB.
- MEM: dmem_req=1. dmem_addr = lut_out (LW/SW) or latched r0[ADDR_W-1:0] (LWR). dmem_we=1 for SW, dmem_wdata=latched A.
  - addr/we/wdata are registered and stable for the whole request.
  - On dmem_ready: loads latch dmem_rdata -> WB; SW pulses pc_inc -> FETCH.
- WB (1 cycle): rf_we=1 and pc_inc=1, then -> FETCH.
  - LW/SET/MOV: rf_waddr from IR[5] / IR[5] / IR[1].
  - R-group: rf_waddr = IR[5:2].
  - rf_wdata: SET gives zero-extended imm; LW/LWR give loaded data; MOV gives A; ALU ops give the latched result.
- Zero-wait latency:
  - BR: 3 cycles.
  - ALU/SET/MOV: 4 cycles.
  - SW: 4 cycles.
  - LW/LWR: 5 cycles.
  - Each wait cycle on imem/dmem adds 1.
- Exactly one of pc_inc/pc_branch pulses per retired instruction; never both.
- HALTED: halted=1, all other outputs 0; exits only on reset. start is ignored outside IDLE.
- Reset while dmem_req=1: request drops the next cycle; any dmem_ready arriving later is ignored.

Optional Feature:
PERF_CNT_EN:
- When defined, adds outputs perf_cycles (32) and perf_retired (32).
- perf_cycles counts cycles with state != IDLE/HALTED.
- perf_retired increments on each pc_inc/pc_branch pulse.
- Both are zeroed on reset and saturate at 2^32-1.
- When undefined, the ports and counters are absent.

Test Plan:
- Reset, start, SET r1,5 (imem zero-wait) -> WB cycle 4 after start: rf_we=1, rf_waddr=1, rf_wdata=5; pc_inc same cycle.
- r0=3, r1=3, BEQ -> pc_branch=1 in EXEC (cycle 3), no rf_we. Repeat with BNE -> pc_inc=1, pc_branch=0.
- SW with lut_out=0x20, r1=0xAB, dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with addr 0x20, wdata 0xAB, we=1 stable; single pc_inc.
- LWR with r0=0x10, dmem_rdata=0x7E -> dmem_addr=0x10, we=0; WB writes 0x7E to IR[5:2] reg.
- HALT -> halted=1 next cycle, no further imem_req; start pulses ignored; reset -> IDLE, halted=0.
- Reset asserted mid-MEM with dmem_req=1 -> dmem_req=0 the next cycle, state IDLE; late dmem_ready causes no rf_we.
